// File: rtl/sdiv_share_arbiter.sv
// Shares one registered scalar_divide unit between two requesters: round-robin issue,
// per-requester credits, tag-routed result FIFOs. Define SDIV_ARB_PKT_LOCK_EN for packet-atomic grants.
module sdiv_share_arbiter #(
    parameter int MAT_WIDTH    = 4,
    parameter int MAT_HEIGHT   = 4,
    parameter int ELEMENT_SIZE = 32,
    parameter int OUT_DEPTH    = 2
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] r0_a_tdata,
    input  logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] r0_b_tdata,
    input  logic                                         r0_tvalid,
    input  logic                                         r0_tlast,
    output logic                                         r0_tready,
    output logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] r0_m_tdata,
    output logic                                         r0_m_tvalid,
    output logic                                         r0_m_tlast,
    input  logic                                         r0_m_tready,
    input  logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] r1_a_tdata,
    input  logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] r1_b_tdata,
    input  logic                                         r1_tvalid,
    input  logic                                         r1_tlast,
    output logic                                         r1_tready,
    output logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] r1_m_tdata,
    output logic                                         r1_m_tvalid,
    output logic                                         r1_m_tlast,
    input  logic                                         r1_m_tready,
    output logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] u_a_tdata,
    output logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] u_b_tdata,
    output logic                                         u_tvalid,
    output logic                                         u_tlast,
    output logic                                         u_a_tuser,
    input  logic                                         u_tready,
    input  logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] u_m_tdata,
    input  logic                                         u_m_tvalid,
    input  logic                                         u_m_tlast,
    input  logic [1:0]                                   u_m_tuser,
    output logic                                         u_m_tready,
    output logic                                         err
);

    localparam int D   = MAT_WIDTH * MAT_HEIGHT * ELEMENT_SIZE;
    localparam int CW  = $clog2(OUT_DEPTH + 1);
    localparam int OPW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int TD  = 2 * OUT_DEPTH;
    localparam int TPW = $clog2(TD);
    localparam int TCW = $clog2(TD + 1);

    function automatic logic [OPW-1:0] of_next(input logic [OPW-1:0] p);
        return (p == OPW'(OUT_DEPTH - 1)) ? '0 : p + OPW'(1);
    endfunction

    function automatic logic [TPW-1:0] tag_next(input logic [TPW-1:0] p);
        return (p == TPW'(TD - 1)) ? '0 : p + TPW'(1);
    endfunction

    logic [1:0]      w_req_vld;
    logic [1:0]      w_m_tready;
    logic [1:0]      w_elig;
    logic [1:0]      w_of_vld;
    logic [1:0][D:0] w_of_head;
    logic            w_rr_vld;
    logic            w_rr_id;
    logic            w_gnt_vld;
    logic            w_gnt_id;
    logic            w_gnt_last;
    logic            w_fire;
    logic            r_last_gnt;
    logic            r_err;
    logic            w_unused;

    assign w_req_vld  = {r1_tvalid, r0_tvalid};
    assign w_m_tready = {r1_m_tready, r0_m_tready};
    assign w_unused   = u_m_tuser[0];

    // Round-robin choice: on contention, the requester that did not win last time.
    always_comb begin
        w_rr_vld = |w_elig;
        w_rr_id  = w_elig[1] & (~w_elig[0] | ~r_last_gnt);
    end

    assign w_gnt_last = w_gnt_id ? r1_tlast : r0_tlast;
    assign w_fire     = w_gnt_vld & u_tready;

`ifdef SDIV_ARB_PKT_LOCK_EN
    typedef enum logic [1:0] {ST_IDLE, ST_LOCK0, ST_LOCK1} state_t;
    state_t r_state;
    state_t w_state_nxt;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_vld   = w_rr_vld;
        w_gnt_id    = w_rr_id;
        case (r_state)
            ST_IDLE: begin
                if (w_fire && !w_gnt_last) w_state_nxt = w_gnt_id ? ST_LOCK1 : ST_LOCK0;
            end
            ST_LOCK0: begin
                w_gnt_vld = w_elig[0];
                w_gnt_id  = 1'b0;
                if (w_fire && w_gnt_last) w_state_nxt = ST_IDLE;
            end
            ST_LOCK1: begin
                w_gnt_vld = w_elig[1];
                w_gnt_id  = 1'b1;
                if (w_fire && w_gnt_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end
`else
    always_comb begin
        w_gnt_vld = w_rr_vld;
        w_gnt_id  = w_rr_id;
    end
`endif

    assign r0_tready  = w_fire & ~w_gnt_id;
    assign r1_tready  = w_fire & w_gnt_id;
    assign u_tvalid   = w_gnt_vld;
    assign u_tlast    = w_gnt_vld & w_gnt_last;
    assign u_a_tuser  = w_gnt_vld & w_gnt_id;
    assign u_a_tdata  = w_gnt_vld ? (w_gnt_id ? r1_a_tdata : r0_a_tdata) : '0;
    assign u_b_tdata  = w_gnt_vld ? (w_gnt_id ? r1_b_tdata : r0_b_tdata) : '0;
    assign u_m_tready = 1'b1;

    always_ff @(posedge clk) begin
        if (reset)       r_last_gnt <= 1'b1;
        else if (w_fire) r_last_gnt <= w_gnt_id;
    end

    // Tag FIFO: requester id of each beat in flight through the unit, in issue order.
    logic           r_tag_mem [TD];
    logic [TPW-1:0] r_tag_wr;
    logic [TPW-1:0] r_tag_rd;
    logic [TCW-1:0] r_tag_cnt;
    logic           w_tag_empty;
    logic           w_tag_pop;
    logic           w_tag_head;

    assign w_tag_empty = (r_tag_cnt == '0);
    assign w_tag_pop   = u_m_tvalid & ~w_tag_empty;
    assign w_tag_head  = r_tag_mem[r_tag_rd];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_wr  <= '0;
            r_tag_rd  <= '0;
            r_tag_cnt <= '0;
        end else begin
            if (w_fire)    r_tag_wr <= tag_next(r_tag_wr);
            if (w_tag_pop) r_tag_rd <= tag_next(r_tag_rd);
            r_tag_cnt <= r_tag_cnt + TCW'(w_fire) - TCW'(w_tag_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) r_tag_mem[r_tag_wr] <= w_gnt_id;
    end

    always_ff @(posedge clk) begin
        if (reset) r_err <= 1'b0;
        else if (u_m_tvalid && (w_tag_empty || (u_m_tuser[1] != w_tag_head))) r_err <= 1'b1;
    end

    assign err = r_err;

    // Per-requester credit counter and first-word-fall-through result FIFO.
    for (genvar g = 0; g < 2; g++) begin : g_req
        logic [CW-1:0]  r_credit;
        logic [D:0]     r_mem [OUT_DEPTH];
        logic [OPW-1:0] r_wr;
        logic [OPW-1:0] r_rd;
        logic [CW-1:0]  r_cnt;
        logic           w_iss;
        logic           w_pop;
        logic           w_full;
        logic           w_push;

        assign w_iss  = w_fire & (w_gnt_id == 1'(g));
        assign w_pop  = (r_cnt != '0) & w_m_tready[g];
        assign w_full = (r_cnt == CW'(OUT_DEPTH));
        assign w_push = w_tag_pop & (w_tag_head == 1'(g)) & (~w_full | w_pop);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_credit <= CW'(OUT_DEPTH);
            end else if (w_iss && !w_pop && (r_credit != '0)) begin
                r_credit <= r_credit - CW'(1);
            end else if (w_pop && !w_iss && (r_credit != CW'(OUT_DEPTH))) begin
                r_credit <= r_credit + CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_wr  <= '0;
                r_rd  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) r_wr <= of_next(r_wr);
                if (w_pop)  r_rd <= of_next(r_rd);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end

        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wr] <= {u_m_tlast, u_m_tdata};
        end

        assign w_elig[g]    = w_req_vld[g] & (r_credit != '0) & ~reset;
        assign w_of_vld[g]  = (r_cnt != '0);
        assign w_of_head[g] = w_of_vld[g] ? r_mem[r_rd] : '0;
    end

    assign r0_m_tvalid = w_of_vld[0];
    assign r0_m_tdata  = w_of_head[0][D-1:0];
    assign r0_m_tlast  = w_of_head[0][D];
    assign r1_m_tvalid = w_of_vld[1];
    assign r1_m_tdata  = w_of_head[1][D-1:0];
    assign r1_m_tlast  = w_of_head[1][D];

endmodule

// File: tb/tb_sdiv_share_arbiter.sv
// Scoreboard bench for sdiv_share_arbiter with a behavioural 1-cycle complex-divide unit.
module tb_sdiv_share_arbiter;

    localparam int NEL = 16;
    localparam int D   = NEL * 32;

    typedef struct { logic [D-1:0] a; logic [D-1:0] b; logic last; } beat_t;
    typedef struct { logic [D:0] v; int t; } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [D-1:0] r0_a_tdata, r0_b_tdata, r1_a_tdata, r1_b_tdata;
    logic r0_tvalid, r0_tlast, r0_tready, r1_tvalid, r1_tlast, r1_tready;
    logic [D-1:0] r0_m_tdata, r1_m_tdata;
    logic r0_m_tvalid, r0_m_tlast, r0_m_tready, r1_m_tvalid, r1_m_tlast, r1_m_tready;
    logic [D-1:0] u_a_tdata, u_b_tdata;
    logic u_tvalid, u_tlast, u_a_tuser, u_tready;
    logic [D-1:0] u_m_tdata = '0;
    logic u_m_tvalid = 1'b0;
    logic u_m_tlast = 1'b0;
    logic [1:0] u_m_tuser = 2'b00;
    logic u_m_tready, err;

    sdiv_share_arbiter #(.MAT_WIDTH(4), .MAT_HEIGHT(4), .ELEMENT_SIZE(32), .OUT_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .r0_a_tdata(r0_a_tdata), .r0_b_tdata(r0_b_tdata), .r0_tvalid(r0_tvalid),
        .r0_tlast(r0_tlast), .r0_tready(r0_tready),
        .r0_m_tdata(r0_m_tdata), .r0_m_tvalid(r0_m_tvalid), .r0_m_tlast(r0_m_tlast),
        .r0_m_tready(r0_m_tready),
        .r1_a_tdata(r1_a_tdata), .r1_b_tdata(r1_b_tdata), .r1_tvalid(r1_tvalid),
        .r1_tlast(r1_tlast), .r1_tready(r1_tready),
        .r1_m_tdata(r1_m_tdata), .r1_m_tvalid(r1_m_tvalid), .r1_m_tlast(r1_m_tlast),
        .r1_m_tready(r1_m_tready),
        .u_a_tdata(u_a_tdata), .u_b_tdata(u_b_tdata), .u_tvalid(u_tvalid), .u_tlast(u_tlast),
        .u_a_tuser(u_a_tuser), .u_tready(u_tready),
        .u_m_tdata(u_m_tdata), .u_m_tvalid(u_m_tvalid), .u_m_tlast(u_m_tlast),
        .u_m_tuser(u_m_tuser), .u_m_tready(u_m_tready), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // Complex element divide, truncating toward zero; zero divisor gives zero.
    function automatic logic [31:0] cdiv_el(input logic [31:0] a, input logic [31:0] b);
        longint ar, ai, br, bi, den, qr, qi;
        ar = longint'($signed(a[15:0]));
        ai = longint'($signed(a[31:16]));
        br = longint'($signed(b[15:0]));
        bi = longint'($signed(b[31:16]));
        den = br * br + bi * bi;
        if (den == 0) return 32'h0;
        qr = (ar * br + ai * bi) / den;
        qi = (ai * br - ar * bi) / den;
        return {qi[15:0], qr[15:0]};
    endfunction

    function automatic logic [D-1:0] cdiv_mat(input logic [D-1:0] a, input logic [D-1:0] b);
        logic [D-1:0] q;
        for (int i = 0; i < NEL; i++) q[i*32 +: 32] = cdiv_el(a[i*32 +: 32], b[i*32 +: 32]);
        return q;
    endfunction

    // Behavioural stand-in for the shared divide unit (registered, in order).
    logic inj = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            u_m_tvalid <= 1'b0;
        end else if (inj) begin
            u_m_tvalid <= 1'b1;
            u_m_tdata  <= '0;
            u_m_tlast  <= 1'b0;
            u_m_tuser  <= 2'b00;
        end else if (u_tvalid && u_tready) begin
            u_m_tvalid <= 1'b1;
            u_m_tdata  <= cdiv_mat(u_a_tdata, u_b_tdata);
            u_m_tlast  <= u_tlast;
            u_m_tuser  <= {u_a_tuser, 1'b0};
        end else begin
            u_m_tvalid <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [D:0] act, input logic [D:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, expv);
        end
    endtask

    beat_t pend0[$], pend1[$];
    exp_t  exp0[$], exp1[$];
    int    glog[$];
    int    n_iss0 = 0, n_iss1 = 0;
    bit    rdy0 = 0, rdy1 = 0, rnd_mode = 0, lat_chk = 0;
    logic [D-1:0] last_r0 = '0;

    function automatic logic [D-1:0] rnd_a();
        logic [D-1:0] v;
        for (int i = 0; i < NEL; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [D-1:0] rnd_b();
        logic [D-1:0] v;
        logic [15:0] re, im;
        for (int i = 0; i < NEL; i++) begin
            re = 16'($urandom_range(1, 40));
            im = 16'($urandom_range(0, 7));
            v[i*32 +: 32] = {im, re};
        end
        return v;
    endfunction

    function automatic beat_t mk(input bit last);
        beat_t bt;
        bt.a = rnd_a();
        bt.b = rnd_b();
        bt.last = last;
        return bt;
    endfunction

    // Monitor: every accepted result is compared with the oldest expected entry of that port.
    task automatic mon(input int r, input logic [D:0] v);
        exp_t e;
        if ((r == 0 && exp0.size() == 0) || (r == 1 && exp1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_result_r%0d got=%0h", r, v);
            return;
        end
        if (r == 0) e = exp0.pop_front();
        else        e = exp1.pop_front();
        chk($sformatf("result_r%0d", r), v, e.v);
        if (lat_chk) chk("latency", D'(cyc - e.t), 2);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (r0_m_tvalid && r0_m_tready) begin
                last_r0 = r0_m_tdata;
                mon(0, {r0_m_tlast, r0_m_tdata});
            end
            if (r1_m_tvalid && r1_m_tready) mon(1, {r1_m_tlast, r1_m_tdata});
        end
    end

    // One clock of stimulus; accepted beats push their expected quotient.
    task automatic cycle1();
        @(posedge clk);
        #1;
        if (rnd_mode) begin
            rdy0 = 1'($urandom_range(0, 1));
            rdy1 = 1'($urandom_range(0, 1));
            u_tready = ($urandom_range(0, 3) != 0);
        end
        r0_m_tready = rdy0;
        r1_m_tready = rdy1;
        r0_tvalid = (pend0.size() > 0);
        r1_tvalid = (pend1.size() > 0);
        if (r0_tvalid) begin r0_a_tdata = pend0[0].a; r0_b_tdata = pend0[0].b; r0_tlast = pend0[0].last; end
        if (r1_tvalid) begin r1_a_tdata = pend1[0].a; r1_b_tdata = pend1[0].b; r1_tlast = pend1[0].last; end
        @(negedge clk);
        if (r0_tready && pend0.size() > 0) begin
            exp0.push_back('{v: {pend0[0].last, cdiv_mat(pend0[0].a, pend0[0].b)}, t: cyc});
            glog.push_back(0);
            n_iss0++;
            void'(pend0.pop_front());
        end
        if (r1_tready && pend1.size() > 0) begin
            exp1.push_back('{v: {pend1[0].last, cdiv_mat(pend1[0].a, pend1[0].b)}, t: cyc});
            glog.push_back(1);
            n_iss1++;
            void'(pend1.pop_front());
        end
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((pend0.size() + pend1.size() + exp0.size() + exp1.size()) > 0 && n < budget) begin
            cycle1();
            n++;
        end
        chk("drain_in_budget", D'(n < budget), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        r0_tvalid = 0; r1_tvalid = 0; inj = 0;
        rdy0 = 0; rdy1 = 0; r0_m_tready = 0; r1_m_tready = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pend0.delete(); pend1.delete(); exp0.delete(); exp1.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int base, viol, last0, first1;
        beat_t bt;
        reset = 1'b1;
        r0_tvalid = 0; r1_tvalid = 0; r0_tlast = 0; r1_tlast = 0;
        r0_a_tdata = '0; r0_b_tdata = '0; r1_a_tdata = '0; r1_b_tdata = '0;
        r0_m_tready = 0; r1_m_tready = 0; u_tready = 1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_u_tvalid", D'(u_tvalid), 0);
        chk("rst_r0_tready", D'(r0_tready), 0);
        chk("rst_r0_m_tvalid", D'(r0_m_tvalid), 0);
        chk("rst_r1_m_tvalid", D'(r1_m_tvalid), 0);
        chk("rst_err", D'(err), 0);
        chk("rst_u_m_tready", D'(u_m_tready), 1);
        chk("rst_u_a_tdata", {1'b0, u_a_tdata}, 0);

        // Only r0: fixed 0x0400_0800 / 4 per element, 2-cycle latency.
        for (int i = 0; i < NEL; i++) begin
            bt.a[i*32 +: 32] = 32'h0400_0800;
            bt.b[i*32 +: 32] = 32'h0000_0004;
        end
        bt.last = 1'b0;
        pend0.push_back(bt); pend0.push_back(bt);
        bt.last = 1'b1;
        pend0.push_back(bt);
        rdy0 = 1; rdy1 = 1;
        base = n_iss0;
        lat_chk = 1;
        run_idle(40);
        lat_chk = 0;
        chk("t1_issues", D'(n_iss0 - base), 3);
        chk("t1_elem0", D'(last_r0[31:0]), 32'h0100_0200);
        chk("t1_elem15", D'(last_r0[D-1 -: 32]), 32'h0100_0200);
        chk("t1_err", D'(err), 0);

        // Both requesters continuously valid with single-beat packets.
        glog.delete();
        for (int i = 0; i < 6; i++) begin pend0.push_back(mk(1)); pend1.push_back(mk(1)); end
        run_idle(100);
        viol = 0;
        for (int i = 1; i < glog.size(); i++) if (glog[i] == glog[i-1]) viol++;
        chk("t2_grants", D'(glog.size()), 12);
        chk("t2_alternate", D'(viol), 0);

        // Credits: output held off, then one pop lets one more beat in.
        rdy0 = 0;
        for (int i = 0; i < 6; i++) pend0.push_back(mk(1));
        base = n_iss0;
        repeat (8) cycle1();
        chk("t3_two_issues", D'(n_iss0 - base), 2);
        chk("t3_stalled", D'(r0_tready), 0);
        rdy0 = 1;
        cycle1();
        rdy0 = 0;
        repeat (6) cycle1();
        chk("t3_one_more", D'(n_iss0 - base), 3);
        rdy0 = 1;
        run_idle(100);

        // r0 four-beat packet starting first, r1 contending throughout.
        glog.delete();
        for (int i = 0; i < 4; i++) pend0.push_back(mk(i == 3));
        cycle1();
        for (int i = 0; i < 4; i++) pend1.push_back(mk(1));
        run_idle(100);
        last0 = -1; first1 = -1;
        for (int i = 0; i < glog.size(); i++) begin
            if (glog[i] == 0) last0 = i;
            if (glog[i] == 1 && first1 < 0) first1 = i;
        end
`ifdef SDIV_ARB_PKT_LOCK_EN
        chk("t4_packet_atomic", D'(last0 < first1), 1);
`else
        chk("t4_interleaved", D'(first1 < last0), 1);
`endif

        // Randomized traffic, back-pressure and unit stalls.
        rnd_mode = 1;
        for (int i = 0; i < 30; i++) begin
            pend0.push_back(mk((i == 29) ? 1'b1 : 1'($urandom_range(0, 1))));
            pend1.push_back(mk((i == 29) ? 1'b1 : 1'($urandom_range(0, 1))));
        end
        run_idle(3000);
        rnd_mode = 0;
        u_tready = 1; rdy0 = 1; rdy1 = 1;
        chk("t5_err", D'(err), 0);

        // Reset with two results outstanding.
        rdy0 = 0;
        pend0.push_back(mk(1)); pend0.push_back(mk(1));
        base = n_iss0;
        repeat (4) cycle1();
        chk("t6_outstanding", D'(n_iss0 - base), 2);
        chk("t6_held", D'(r0_m_tvalid), 1);
        do_reset();
        @(negedge clk);
        chk("t6_r0_m_tvalid", D'(r0_m_tvalid), 0);
        chk("t6_r1_m_tvalid", D'(r1_m_tvalid), 0);
        chk("t6_u_tvalid", D'(u_tvalid), 0);
        chk("t6_err", D'(err), 0);
        for (int i = 0; i < 3; i++) pend0.push_back(mk(1));
        base = n_iss0;
        repeat (6) cycle1();
        chk("t6_credit_restored", D'(n_iss0 - base), 2);
        base = n_iss1;
        pend1.push_back(mk(1));
        rdy0 = 1; rdy1 = 1;
        run_idle(100);
        chk("t6_r1_fresh", D'(n_iss1 - base), 1);

        // Spurious unit result with nothing issued.
        @(posedge clk);
        #1 inj = 1'b1;
        @(posedge clk);
        #1 inj = 1'b0;
        repeat (3) @(negedge clk);
        chk("t7_err_set", D'(err), 1);
        chk("t7_no_route", D'(r0_m_tvalid | r1_m_tvalid), 0);
        repeat (5) @(negedge clk);
        chk("t7_err_sticky", D'(err), 1);
        do_reset();
        @(negedge clk);
        chk("t7_err_cleared", D'(err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
